// File: rtl/hex_bus_display.sv
// Seven-segment bus monitor: snapshots addr/data on a capture strobe and pages the
// selected bus across the hex digits, with a bus tag on the top two digits.
module hex_bus_display #(
    parameter int DATA_W      = 32,
    parameter int NUM_DIGITS  = 6,
    parameter int PAGE_TICKS  = 50_000_000,
    parameter int FLASH_TICKS = 5_000_000,
    parameter bit ACTIVE_LOW  = 1'b1,
    localparam int ND    = NUM_DIGITS - 2,
    localparam int PAGES = DATA_W / (4 * ND),
    localparam int PW    = (PAGES > 1) ? $clog2(PAGES) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_W-1:0]       addr,
    input  logic [DATA_W-1:0]       data,
    input  logic                    capture,
    input  logic                    freeze,
    input  logic                    sel_data,
    input  logic                    auto_page,
    input  logic                    page_btn,
    output logic [NUM_DIGITS*8-1:0] hex,
    output logic [PW-1:0]           page,
    output logic                    flash
);

    localparam int TW = $clog2(PAGE_TICKS);
    localparam int FW = $clog2(FLASH_TICKS + 1);
    localparam logic [TW-1:0] TIMER_TC   = TW'(PAGE_TICKS - 1);
    localparam logic [FW-1:0] FLASH_LOAD = FW'(FLASH_TICKS);
    localparam logic [PW-1:0] LAST_PAGE  = PW'(PAGES - 1);
    localparam logic [6:0]    SEG_A      = 7'h77;
    localparam logic [6:0]    SEG_D      = 7'h5E;

    logic [DATA_W-1:0]       addr_snap;
    logic [DATA_W-1:0]       data_snap;
    logic [TW-1:0]           timer;
    logic [FW-1:0]           flash_cnt;
    logic [1:0]              btn_sync;
    logic                    btn_prev;
    logic                    btn_rise;
    logic                    at_tc;
    logic                    advance;
    logic [PW-1:0]           page_next;
    logic [DATA_W-1:0]       src;
    logic [NUM_DIGITS*8-1:0] hex_d;

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        case (nib)
            4'h0: seg7 = 7'h3F;
            4'h1: seg7 = 7'h06;
            4'h2: seg7 = 7'h5B;
            4'h3: seg7 = 7'h4F;
            4'h4: seg7 = 7'h66;
            4'h5: seg7 = 7'h6D;
            4'h6: seg7 = 7'h7D;
            4'h7: seg7 = 7'h07;
            4'h8: seg7 = 7'h7F;
            4'h9: seg7 = 7'h6F;
            4'hA: seg7 = 7'h77;
            4'hB: seg7 = 7'h7C;
            4'hC: seg7 = 7'h39;
            4'hD: seg7 = 7'h5E;
            4'hE: seg7 = 7'h79;
            default: seg7 = 7'h71;
        endcase
    endfunction

    assign btn_rise  = btn_sync[1] & ~btn_prev;
    assign at_tc     = auto_page && (timer == TIMER_TC);
    assign advance   = btn_rise || at_tc;
    assign page_next = (page == LAST_PAGE) ? '0 : page + PW'(1);
    assign flash     = (flash_cnt != '0);

    // Display image is built from the state before the edge, so hex lags state by one cycle.
    always_comb begin
        src   = sel_data ? data_snap : addr_snap;
        hex_d = '0;
        for (int j = 0; j < ND; j++) begin
            hex_d[8*j +: 7] = seg7(4'(src >> (int'(page) * 4 * ND + 4 * j)));
        end
        hex_d[7]              = (page != '0);
        hex_d[8*ND +: 7]      = sel_data ? SEG_A : SEG_D;
        hex_d[8*(ND+1) +: 7]  = sel_data ? SEG_D : SEG_A;
        hex_d[8*(ND+1) + 7]   = flash;
        hex_d                 = hex_d ^ {(NUM_DIGITS*8){ACTIVE_LOW}};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_snap <= '0;
            data_snap <= '0;
            page      <= '0;
            timer     <= '0;
            flash_cnt <= '0;
            btn_sync  <= '0;
            btn_prev  <= 1'b0;
            hex       <= {(NUM_DIGITS*8){ACTIVE_LOW}};
        end else begin
            btn_sync <= {btn_sync[0], page_btn};
            btn_prev <= btn_sync[1];

            if (capture && !freeze) begin
                addr_snap <= addr;
                data_snap <= data;
                flash_cnt <= FLASH_LOAD;
            end else if (flash_cnt != '0) begin
                flash_cnt <= flash_cnt - FW'(1);
            end

            if (advance) begin
                page <= page_next;
            end

            // A button edge wins over the timer and restarts the auto-page period.
            if (btn_rise || !auto_page || at_tc) begin
                timer <= '0;
            end else begin
                timer <= timer + TW'(1);
            end

            hex <= hex_d;
        end
    end

endmodule
